// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
// Holds the state encoding and the requester indices.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN0  = 2'b01,
        OWN1  = 2'b10,
        DRAIN = 2'b11
    } arb_state_e;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the two cache controllers, the arbiter and banked memory.
// master = controller/memory side, slave = arbiter.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [1:0]    lock_req;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    req_rd;
    logic [1:0]    req_wr;
    logic [1:0]    grant;
    logic [1:0]    req_stall;
    logic [3:0]    req_busy0;
    logic [3:0]    req_busy1;
    logic [DW-1:0] req_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_data_out;
    logic          mem_stall;
    logic [3:0]    mem_busy;
    logic          arb_err;

    modport slave (
        input  lock_req, req_addr0, req_addr1,
        input  req_wdata0, req_wdata1, req_rd, req_wr,
        input  mem_data_out, mem_stall, mem_busy,
        output grant, req_stall, req_busy0, req_busy1,
        output req_rdata, mem_addr, mem_data_in,
        output mem_read, mem_write, arb_err
    );

    modport master (
        output lock_req, req_addr0, req_addr1,
        output req_wdata0, req_wdata1, req_rd, req_wr,
        output mem_data_out, mem_stall, mem_busy,
        input  grant, req_stall, req_busy0, req_busy1,
        input  req_rdata, mem_addr, mem_data_in,
        input  mem_read, mem_write, arb_err
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick: ptr names the tie winner,
// and the pointer moves to the loser only when both request.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick,
    output logic       ptr_nxt
);

    always_comb begin
        pick    = 2'b00;
        ptr_nxt = ptr;
        case (req)
            2'b01: pick = 2'b01;
            2'b10: pick = 2'b10;
            2'b11: begin
                pick    = ptr ? 2'b10 : 2'b01;
                ptr_nxt = ~ptr;
            end
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Grants main memory to the I-side or D-side controller for a whole
// line transaction, drains bank activity between owners, watchdogs holds.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 64,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic          rr_ptr;
    logic          rr_ptr_nxt;
    logic          rr_take;
    logic [1:0]    pick;
    logic [CW-1:0] hold_cnt;
    logic          own;
    logic          own_d;
    logic          own_lock;
    logic          own_rd;
    logic          own_wr;
    logic          timeout;
    logic          err_set;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    arb_rr2 u_rr (
        .req     (bus.lock_req),
        .ptr     (rr_ptr),
        .pick    (pick),
        .ptr_nxt (rr_ptr_nxt)
    );

    assign own      = (state == OWN0) || (state == OWN1);
    assign own_d    = (state == OWN1);
    assign own_lock = bus.lock_req[own_d];
    // Strobes from a requester whose lock is low never reach memory.
    assign own_rd   = own & own_lock & bus.req_rd[own_d];
    assign own_wr   = own & own_lock & bus.req_wr[own_d];
    assign timeout  = own && (hold_cnt == HOLD_LAST);

    assign err_set = (own_rd & own_wr) | timeout |
                     (|((bus.req_rd | bus.req_wr) & ~bus.lock_req));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_take   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.lock_req && !(|bus.mem_busy)) begin
                    rr_take   = 1'b1;
                    state_nxt = pick[REQ_D] ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!bus.lock_req[REQ_I] || timeout) state_nxt = DRAIN;
            end
            OWN1: begin
                if (!bus.lock_req[REQ_D] || timeout) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!(|bus.mem_busy)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            hold_cnt <= '0;
            bus.grant   <= 2'b00;
            bus.arb_err <= 1'b0;
        end else begin
            if (rr_take) rr_ptr <= rr_ptr_nxt;
            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (own && !timeout) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
            unique case (state_nxt)
                OWN0:    bus.grant <= 2'b01;
                OWN1:    bus.grant <= 2'b10;
                default: bus.grant <= 2'b00;
            endcase
            if (err_set) bus.arb_err <= 1'b1;
        end
    end

    always_comb begin
        addr_mux      = '0;
        wdata_mux     = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.req_stall = 2'b11;
        bus.req_busy0 = 4'hF;
        bus.req_busy1 = 4'hF;
        if (own) begin
            addr_mux  = own_d ? bus.req_addr1 : bus.req_addr0;
            wdata_mux = own_d ? bus.req_wdata1 : bus.req_wdata0;
            // A read+write collision is forwarded as a write only.
            bus.mem_write = own_wr;
            bus.mem_read  = own_rd & ~own_wr;
        end
        unique case (state)
            OWN0: begin
                bus.req_stall[REQ_I] = bus.mem_stall;
                bus.req_busy0        = bus.mem_busy;
            end
            OWN1: begin
                bus.req_stall[REQ_D] = bus.mem_stall;
                bus.req_busy1        = bus.mem_busy;
            end
            default: begin
                bus.req_busy0 = 4'hF;
            end
        endcase
    end

    assign bus.mem_addr    = addr_mux;
    assign bus.mem_data_in = wdata_mux;
    assign bus.req_rdata   = bus.mem_data_out;

endmodule
